parking_gate_controller: RTL and testbench
==========================================

Name: parking_gate_controller

Overview:
- Parametrised next-generation occupancy controller for the campus car park, with two classes: general and university (uni).
- Adds an entry-gate handshake FSM (request, grant or deny, pass or timeout) and reserves a slot while a car is at the gate.
- Applies entry and exit of the same class in the same cycle as a net change.
- Flags over-capacity when the hour-based schedule shrinks a class below its current occupancy.
- Sits between the gate sensors/barrier driver and the occupancy display.

Parameters:
- TOTAL_CAP, 700: total spaces, general plus uni.
- CNT_W, 10: width of counters and space outputs; must satisfy 2^CNT_W > TOTAL_CAP.
- OFFPEAK_FREE, 500: general capacity outside peak hours.
- PEAK_FREE, 200: general capacity during peak hours.
- PEAK_START, 8: first peak hour.
- PEAK_END, 13: first ramp hour.
- RAMP_END, 16: first off-peak hour after the ramp.
- RAMP_STEP, 50: general capacity added per ramp hour.
- GATE_TIMEOUT, 16: cycles in GRANT before the slot is released.
- TO_W, 5: timeout counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- current_hour  in  5  hour of day, 0..23; values 24..31 are treated as off-peak.
- entry_req  in  1  car present at the entry gate (level).
- entry_is_uni  in  1  class of the requesting car; sampled only in IDLE.
- entry_passed  in  1  barrier loop confirms the car has passed (pulse).
- exit_event  in  1  a car left the park (pulse).
- exit_is_uni  in  1  class of the exiting car.
- entry_grant  out  1  open barrier; level, held while in GRANT.
- entry_deny  out  1  one-cycle pulse: no space for the requesting class.
- entry_timeout  out  1  one-cycle pulse: grant expired without a pass.
- parked_car  out  CNT_W  general occupancy.
- uni_parked_car  out  CNT_W  uni occupancy.
- vacated_space  out  CNT_W  free general spaces, saturating.
- uni_vacated_space  out  CNT_W  free uni spaces, saturating.
- is_vacated_space  out  1  vacated_space != 0.
- uni_is_vacated_space  out  1  uni_vacated_space != 0.
- over_capacity  out  1  either class occupancy exceeds its current capacity.
- exit_underflow  out  1  sticky: exit seen while the class count was 0; cleared only by reset.

Behaviour:
- Reset (async): all counters 0, free_cap = OFFPEAK_FREE, FSM = IDLE, grant/deny/timeout/underflow 0. The grant drops immediately, including mid-GRANT, and any pending reservation is discarded.
- Schedule: free_cap is registered, updated every cycle from current_hour, so it has 1-cycle latency.
  - Hour < PEAK_START: OFFPEAK_FREE.
  - PEAK_START..PEAK_END-1: PEAK_FREE.
  - PEAK_END..RAMP_END-1: PEAK_FREE + (hour - PEAK_END + 1) * RAMP_STEP. With defaults: 13 gives 250, 14 gives 300, 15 gives 350.
  - Hour >= RAMP_END: OFFPEAK_FREE.
- uni_cap = TOTAL_CAP - free_cap.
- Pending slot: pend (1 bit) and pend_uni (class of the pending car) are set while in GRANT.
- Free-space arithmetic, computed at CNT_W+1 bits and saturated to 0:
  - vacated_space = free_cap - parked_car - (pend & !pend_uni).
  - uni_vacated_space = uni_cap - uni_parked_car - (pend & pend_uni).
- over_capacity = (parked_car > free_cap) | (uni_parked_car > uni_cap). The block never evicts cars; it only denies new entries of that class.
- FSM states: IDLE, GRANT, RELEASE.
  - IDLE: if entry_req is high, latch entry_is_uni.
    - If the class has a vacated space: go to GRANT next cycle, set pend, clear the timeout counter. entry_grant rises one cycle after the request.
    - Otherwise: pulse entry_deny for one cycle and go to RELEASE.
  - GRANT: entry_grant = 1; the counter increments each cycle.
    - entry_passed high: increment the class count, clear pend, go to RELEASE.
    - Counter reaches GATE_TIMEOUT-1 without a pass: pulse entry_timeout, clear pend, go to RELEASE.
    - Pass and timeout in the same cycle: the pass wins.
    - entry_req dropping while in GRANT is ignored; only a pass or the timeout ends GRANT.
  - RELEASE: wait for entry_req = 0, then go to IDLE. This prevents one car from generating multiple requests.
  - entry_passed outside GRANT is ignored.
- Exit: on exit_event, decrement the selected class count if it is > 0; otherwise set exit_underflow and leave the count unchanged.
- Simultaneous commit and exit:
  - Same class: count is unchanged (net 0).
  - Different classes: each count updates independently.
- Counters never exceed 2^CNT_W-1. An increment is only possible after a granted vacancy check, so they cannot wrap.

Test Plan:
- Reset, hour 0, uni entry_req -> entry_grant high on the 2nd cycle, uni_vacated_space 199 during GRANT. Pulse entry_passed -> uni_parked_car 1, uni_vacated_space 199, FSM in RELEASE until entry_req drops.
- Hour 9 (free_cap 200), admit 200 general cars -> vacated_space 0, is_vacated_space 0. Next general request -> entry_deny one-cycle pulse, entry_grant never asserted, parked_car stays 200.
- Grant a general car, hold entry_passed low for 16 cycles -> entry_timeout pulse on the 16th GRANT cycle, grant drops, vacated_space restored to its pre-grant value, parked_car unchanged.
- parked_car 50, same cycle as the entry_passed commit of a general car assert general exit_event -> parked_car stays 50. Repeat with a uni exit -> parked_car 51, uni count minus 1.
- 300 general cars parked at hour 7, set hour 8 -> one cycle later free_cap 200, over_capacity 1, vacated_space 0 (saturated), requests denied. Exits bring parked_car to 200 -> over_capacity 0. Hours 13/14/15 -> vacated_space 50/100/150 with parked_car 200.
- Counts 0, general exit_event -> exit_underflow 1 (sticky), parked_car 0. Assert reset mid-GRANT -> entry_grant 0 immediately, all counts 0, exit_underflow 0.

Source files
------------

// File: rtl/parking_gate_controller.sv
// Two-class car-park occupancy controller with an entry-gate handshake FSM,
// an hour-based general/uni capacity split and a slot reservation during GRANT.
module parking_gate_controller #(
    parameter int TOTAL_CAP    = 700,
    parameter int CNT_W        = 10,
    parameter int OFFPEAK_FREE = 500,
    parameter int PEAK_FREE    = 200,
    parameter int PEAK_START   = 8,
    parameter int PEAK_END     = 13,
    parameter int RAMP_END     = 16,
    parameter int RAMP_STEP    = 50,
    parameter int GATE_TIMEOUT = 16,
    parameter int TO_W         = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       current_hour,
    input  logic             entry_req,
    input  logic             entry_is_uni,
    input  logic             entry_passed,
    input  logic             exit_event,
    input  logic             exit_is_uni,
    output logic             entry_grant,
    output logic             entry_deny,
    output logic             entry_timeout,
    output logic [CNT_W-1:0] parked_car,
    output logic [CNT_W-1:0] uni_parked_car,
    output logic [CNT_W-1:0] vacated_space,
    output logic [CNT_W-1:0] uni_vacated_space,
    output logic             is_vacated_space,
    output logic             uni_is_vacated_space,
    output logic             over_capacity,
    output logic             exit_underflow
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] free_cap_q, free_cap_d;
    logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;
    logic [CNT_W-1:0] uni_cnt_q, uni_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             pend_uni_q, pend_uni_d;
    logic             deny_q, deny_d;
    logic             underflow_q, underflow_d;

    logic [CNT_W-1:0] uni_cap;
    logic             pend;
    logic             commit_gen, commit_uni, timeout;
    logic             exit_gen, exit_uni;
    logic             has_space;
    int               hr;

    // Free spaces at CNT_W+1 bits so an over-full class clamps to zero instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_free(input logic [CNT_W-1:0] cap,
                                                  input logic [CNT_W-1:0] used,
                                                  input logic             rsv);
        logic [CNT_W:0] diff;
        diff = {1'b0, cap} - {1'b0, used} - {{CNT_W{1'b0}}, rsv};
        return diff[CNT_W] ? '0 : diff[CNT_W-1:0];
    endfunction

    assign hr = 32'(current_hour);

    always_comb begin
        free_cap_d = CNT_W'(OFFPEAK_FREE);
        if (hr >= PEAK_START && hr < PEAK_END) begin
            free_cap_d = CNT_W'(PEAK_FREE);
        end else if (hr >= PEAK_END && hr < RAMP_END) begin
            free_cap_d = CNT_W'(PEAK_FREE + (hr - PEAK_END + 1) * RAMP_STEP);
        end
    end

    assign uni_cap           = CNT_W'(TOTAL_CAP) - free_cap_q;
    assign pend              = (state_q == GRANT);
    assign vacated_space     = sat_free(free_cap_q, gen_cnt_q, pend & ~pend_uni_q);
    assign uni_vacated_space = sat_free(uni_cap, uni_cnt_q, pend & pend_uni_q);
    assign has_space         = entry_is_uni ? (uni_vacated_space != '0) : (vacated_space != '0);

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        pend_uni_d = pend_uni_q;
        deny_d     = 1'b0;
        commit_gen = 1'b0;
        commit_uni = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (entry_req) begin
                    pend_uni_d = entry_is_uni;
                    if (has_space) begin
                        state_d  = GRANT;
                        to_cnt_d = '0;
                    end else begin
                        deny_d  = 1'b1;
                        state_d = RELEASE;
                    end
                end
            end
            GRANT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // A pass on the last grant cycle still counts as a pass.
                if (entry_passed) begin
                    commit_gen = ~pend_uni_q;
                    commit_uni = pend_uni_q;
                    state_d    = RELEASE;
                end else if (to_cnt_q == TO_W'(GATE_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!entry_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign exit_gen = exit_event & ~exit_is_uni;
    assign exit_uni = exit_event & exit_is_uni;

    always_comb begin
        gen_cnt_d   = gen_cnt_q;
        uni_cnt_d   = uni_cnt_q;
        underflow_d = underflow_q;
        if (commit_gen && !exit_gen) begin
            gen_cnt_d = gen_cnt_q + 1'b1;
        end else if (exit_gen && !commit_gen) begin
            if (gen_cnt_q != '0) gen_cnt_d = gen_cnt_q - 1'b1;
            else                 underflow_d = 1'b1;
        end
        if (commit_uni && !exit_uni) begin
            uni_cnt_d = uni_cnt_q + 1'b1;
        end else if (exit_uni && !commit_uni) begin
            if (uni_cnt_q != '0) uni_cnt_d = uni_cnt_q - 1'b1;
            else                 underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            free_cap_q  <= CNT_W'(OFFPEAK_FREE);
            gen_cnt_q   <= '0;
            uni_cnt_q   <= '0;
            to_cnt_q    <= '0;
            pend_uni_q  <= 1'b0;
            deny_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            free_cap_q  <= free_cap_d;
            gen_cnt_q   <= gen_cnt_d;
            uni_cnt_q   <= uni_cnt_d;
            to_cnt_q    <= to_cnt_d;
            pend_uni_q  <= pend_uni_d;
            deny_q      <= deny_d;
            underflow_q <= underflow_d;
        end
    end

    assign entry_grant          = (state_q == GRANT);
    assign entry_deny           = deny_q;
    assign entry_timeout        = timeout;
    assign parked_car           = gen_cnt_q;
    assign uni_parked_car       = uni_cnt_q;
    assign is_vacated_space     = (vacated_space != '0);
    assign uni_is_vacated_space = (uni_vacated_space != '0);
    assign over_capacity        = (gen_cnt_q > free_cap_q) | (uni_cnt_q > uni_cap);
    assign exit_underflow       = underflow_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller: gate handshake, deny, timeout,
// same-cycle commit/exit, schedule-driven over-capacity and reset behaviour.
module tb_parking_gate_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] current_hour;
    logic       entry_req, entry_is_uni, entry_passed, exit_event, exit_is_uni;
    logic       entry_grant, entry_deny, entry_timeout;
    logic [9:0] parked_car, uni_parked_car, vacated_space, uni_vacated_space;
    logic       is_vacated_space, uni_is_vacated_space, over_capacity, exit_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    parking_gate_controller dut (
        .clk                 (clk),
        .reset               (reset),
        .current_hour        (current_hour),
        .entry_req           (entry_req),
        .entry_is_uni        (entry_is_uni),
        .entry_passed        (entry_passed),
        .exit_event          (exit_event),
        .exit_is_uni         (exit_is_uni),
        .entry_grant         (entry_grant),
        .entry_deny          (entry_deny),
        .entry_timeout       (entry_timeout),
        .parked_car          (parked_car),
        .uni_parked_car      (uni_parked_car),
        .vacated_space       (vacated_space),
        .uni_vacated_space   (uni_vacated_space),
        .is_vacated_space    (is_vacated_space),
        .uni_is_vacated_space(uni_is_vacated_space),
        .over_capacity       (over_capacity),
        .exit_underflow      (exit_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full grant-and-pass handshake for one car; ends back in IDLE with inputs low.
    task automatic admit(input logic uni);
        entry_req    = 1'b1;
        entry_is_uni = uni;
        tick();
        entry_passed = 1'b1;
        tick();
        entry_passed = 1'b0;
        entry_req    = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        current_hour = 5'd0;
        entry_req    = 1'b0;
        entry_is_uni = 1'b0;
        entry_passed = 1'b0;
        exit_event   = 1'b0;
        exit_is_uni  = 1'b0;
        tick();
        tick();
        chk_eq("rst_parked", parked_car, 0);
        chk_eq("rst_uni_parked", uni_parked_car, 0);
        chk_eq("rst_vac", vacated_space, 500);
        chk_eq("rst_uni_vac", uni_vacated_space, 200);
        chk_eq("rst_grant", entry_grant, 0);
        chk_eq("rst_underflow", exit_underflow, 0);
        reset = 1'b0;
        tick();

        // Uni car at hour 0
        entry_req    = 1'b1;
        entry_is_uni = 1'b1;
        chk_eq("t1_grant_c1", entry_grant, 0);
        tick();
        chk_eq("t1_grant_c2", entry_grant, 1);
        chk_eq("t1_uni_vac_rsv", uni_vacated_space, 199);
        chk_eq("t1_gen_vac_rsv", vacated_space, 500);
        entry_passed = 1'b1;
        tick();
        entry_passed = 1'b0;
        chk_eq("t1_uni_parked", uni_parked_car, 1);
        chk_eq("t1_uni_vac_after", uni_vacated_space, 199);
        chk_eq("t1_grant_release", entry_grant, 0);
        tick();
        tick();
        chk_eq("t1_hold_no_regrant", entry_grant, 0);
        entry_req = 1'b0;
        tick();

        // Peak hour, fill general class
        current_hour = 5'd9;
        tick();
        chk_eq("t2_vac_peak", vacated_space, 200);
        for (int i = 0; i < 200; i++) admit(1'b0);
        chk_eq("t2_parked_full", parked_car, 200);
        chk_eq("t2_vac_zero", vacated_space, 0);
        chk_eq("t2_is_vac", is_vacated_space, 0);
        entry_req    = 1'b1;
        entry_is_uni = 1'b0;
        tick();
        chk_eq("t2_deny_pulse", entry_deny, 1);
        chk_eq("t2_no_grant_a", entry_grant, 0);
        tick();
        chk_eq("t2_deny_end", entry_deny, 0);
        chk_eq("t2_no_grant_b", entry_grant, 0);
        chk_eq("t2_parked_hold", parked_car, 200);
        entry_req = 1'b0;
        tick();

        // Grant timeout
        current_hour = 5'd0;
        tick();
        chk_eq("t3_vac_pre", vacated_space, 300);
        entry_req    = 1'b1;
        entry_is_uni = 1'b0;
        tick();
        chk_eq("t3_vac_rsv", vacated_space, 299);
        for (int i = 1; i <= 16; i++) begin
            chk_eq("t3_grant_held", entry_grant, 1);
            chk_eq("t3_timeout", entry_timeout, (i == 16) ? 1 : 0);
            tick();
        end
        chk_eq("t3_grant_drop", entry_grant, 0);
        chk_eq("t3_timeout_end", entry_timeout, 0);
        chk_eq("t3_vac_restored", vacated_space, 300);
        chk_eq("t3_parked_same", parked_car, 200);
        entry_req = 1'b0;
        tick();

        // Same-cycle commit and exit
        pulse_reset();
        for (int i = 0; i < 50; i++) admit(1'b0);
        admit(1'b1);
        chk_eq("t4_parked_50", parked_car, 50);
        entry_req    = 1'b1;
        entry_is_uni = 1'b0;
        tick();
        entry_passed = 1'b1;
        exit_event   = 1'b1;
        exit_is_uni  = 1'b0;
        tick();
        entry_passed = 1'b0;
        exit_event   = 1'b0;
        entry_req    = 1'b0;
        chk_eq("t4_same_class_net", parked_car, 50);
        tick();
        entry_req = 1'b1;
        tick();
        entry_passed = 1'b1;
        exit_event   = 1'b1;
        exit_is_uni  = 1'b1;
        tick();
        entry_passed = 1'b0;
        exit_event   = 1'b0;
        entry_req    = 1'b0;
        chk_eq("t4_diff_gen", parked_car, 51);
        chk_eq("t4_diff_uni", uni_parked_car, 0);
        tick();

        // Schedule shrink below occupancy
        current_hour = 5'd7;
        tick();
        for (int i = 0; i < 249; i++) admit(1'b0);
        chk_eq("t5_parked_300", parked_car, 300);
        current_hour = 5'd8;
        chk_eq("t5_over_latency", over_capacity, 0);
        tick();
        chk_eq("t5_over", over_capacity, 1);
        chk_eq("t5_vac_sat", vacated_space, 0);
        entry_req    = 1'b1;
        entry_is_uni = 1'b0;
        tick();
        chk_eq("t5_deny", entry_deny, 1);
        chk_eq("t5_parked_hold", parked_car, 300);
        entry_req = 1'b0;
        tick();
        exit_event  = 1'b1;
        exit_is_uni = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        chk_eq("t5_over_201", over_capacity, 1);
        tick();
        exit_event = 1'b0;
        chk_eq("t5_parked_200", parked_car, 200);
        chk_eq("t5_over_clear", over_capacity, 0);
        current_hour = 5'd13;
        tick();
        chk_eq("t5_vac_h13", vacated_space, 50);
        current_hour = 5'd14;
        tick();
        chk_eq("t5_vac_h14", vacated_space, 100);
        current_hour = 5'd15;
        tick();
        chk_eq("t5_vac_h15", vacated_space, 150);
        chk_eq("t5_uni_vac_h15", uni_vacated_space, 350);

        // Underflow and asynchronous reset mid-GRANT
        pulse_reset();
        exit_event  = 1'b1;
        exit_is_uni = 1'b0;
        tick();
        exit_event = 1'b0;
        chk_eq("t6_underflow", exit_underflow, 1);
        chk_eq("t6_parked_0", parked_car, 0);
        tick();
        chk_eq("t6_underflow_sticky", exit_underflow, 1);
        admit(1'b0);
        chk_eq("t6_parked_1", parked_car, 1);
        entry_req    = 1'b1;
        entry_is_uni = 1'b0;
        tick();
        chk_eq("t6_grant_pre", entry_grant, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_eq("t6_grant_async", entry_grant, 0);
        chk_eq("t6_parked_rst", parked_car, 0);
        chk_eq("t6_uni_rst", uni_parked_car, 0);
        chk_eq("t6_underflow_rst", exit_underflow, 0);
        entry_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk_eq("t6_idle_after", entry_grant, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
